// File: rtl/sccb_clk_gen.sv
// SCCB/I2C bus-clock generator: programmable half-period, idle-high SCL,
// low-phase stretching and single-cycle phase strobes for the master FSM.
module sccb_clk_gen #(
  parameter int CLK_FREQ      = 10_000_000,
  parameter int SCCB_CLK_FREQ = 100_000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] half_in,
  input  logic             hold,
  output logic             sccb_clk,
  output logic             tick_fall,
  output logic             mid_low,
  output logic             tick_rise,
  output logic             mid_high,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(CLK_FREQ / SCCB_CLK_FREQ / 2);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] count, count_d, count_inc;
  logic [CNT_W-1:0] half_reg, half_d, pend_half, pend_half_d, mid_pt;
  logic             pend_vld, pend_vld_d;
  logic             sccb_clk_d, busy_d, cfg_err_d;
  logic             tick_fall_d, mid_low_d, tick_rise_d, mid_high_d;
  logic             last, enter_low;

  always_comb begin
    state_d     = state;
    count_d     = count;
    half_d      = half_reg;
    pend_half_d = pend_half;
    pend_vld_d  = pend_vld;
    sccb_clk_d  = sccb_clk;
    busy_d      = busy;
    tick_fall_d = 1'b0;
    mid_low_d   = 1'b0;
    tick_rise_d = 1'b0;
    mid_high_d  = 1'b0;
    cfg_err_d   = 1'b0;
    enter_low   = 1'b0;
    count_inc   = count + 1'b1;
    mid_pt      = half_reg >> 1;
    last        = (count == half_reg - 1'b1);

    unique case (state)
      IDLE: begin
        if (enable) enter_low = 1'b1;
      end
      LOW: begin
        // At the last count a held bus freezes the counter silently
        if (!last) begin
          count_d   = count_inc;
          mid_low_d = (count_inc == mid_pt);
        end else if (!hold) begin
          state_d     = HIGH;
          count_d     = '0;
          sccb_clk_d  = 1'b1;
          tick_rise_d = 1'b1;
        end
      end
      HIGH: begin
        if (!last) begin
          count_d    = count_inc;
          mid_high_d = (count_inc == mid_pt);
        end else if (enable) begin
          enter_low = 1'b1;
        end else begin
          state_d = IDLE;
          count_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // New rate only takes effect at a LOW boundary, using pending state
    // captured before this cycle's load
    if (enter_low) begin
      state_d     = LOW;
      count_d     = '0;
      sccb_clk_d  = 1'b0;
      tick_fall_d = 1'b1;
      busy_d      = 1'b1;
      if (pend_vld) begin
        half_d     = pend_half;
        pend_vld_d = 1'b0;
      end
    end

    if (load) begin
      if (half_in < CNT_W'(2)) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_half_d = half_in;
        pend_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= '0;
      half_reg  <= DEF_HALF;
      pend_half <= '0;
      pend_vld  <= 1'b0;
      sccb_clk  <= 1'b1;
      busy      <= 1'b0;
      tick_fall <= 1'b0;
      mid_low   <= 1'b0;
      tick_rise <= 1'b0;
      mid_high  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      half_reg  <= half_d;
      pend_half <= pend_half_d;
      pend_vld  <= pend_vld_d;
      sccb_clk  <= sccb_clk_d;
      busy      <= busy_d;
      tick_fall <= tick_fall_d;
      mid_low   <= mid_low_d;
      tick_rise <= tick_rise_d;
      mid_high  <= mid_high_d;
      cfg_err   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_sccb_clk_gen.sv
// Bench for sccb_clk_gen: per-cycle stimulus plans with an event-timeline
// reference model built from phase lengths (half, stretch, stop point).
`timescale 1ns/1ps
module tb_sccb_clk_gen;
  localparam int CNT_W = 16;
  localparam int MAXC  = 4096;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             enable, load, hold;
  logic [CNT_W-1:0] half_in;
  logic             sccb_clk, tick_fall, mid_low, tick_rise, mid_high, busy, cfg_err;

  sccb_clk_gen dut (
    .clk(clk), .resetn(resetn), .enable(enable), .load(load), .half_in(half_in),
    .hold(hold), .sccb_clk(sccb_clk), .tick_fall(tick_fall), .mid_low(mid_low),
    .tick_rise(tick_rise), .mid_high(mid_high), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  int rc;
  bit logging = 1'b0;
  int q_ev[$];
  int q_err[$];
  bit clk_hist[MAXC];
  bit busy_hist[MAXC];
  int n_glitch = 0;
  int n_overlap = 0;
  logic prev_clk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  assign rc = cyc - base;

  // Observed timeline: one entry per strobe, encoded cycle*4 + kind
  always @(negedge clk) begin
    if (!resetn) begin
      prev_clk <= 1'b1;
    end else begin
      prev_clk <= sccb_clk;
      if ((sccb_clk != prev_clk && !(tick_fall && !sccb_clk) && !(tick_rise && sccb_clk)) ||
          (tick_fall && sccb_clk) || (tick_rise && !sccb_clk))
        n_glitch <= n_glitch + 1;
      if (int'(tick_fall) + int'(mid_low) + int'(tick_rise) + int'(mid_high) > 1)
        n_overlap <= n_overlap + 1;
      if (logging && rc >= 0 && rc < MAXC) begin
        if (tick_fall) q_ev.push_back(rc * 4 + 0);
        if (mid_low)   q_ev.push_back(rc * 4 + 1);
        if (tick_rise) q_ev.push_back(rc * 4 + 2);
        if (mid_high)  q_ev.push_back(rc * 4 + 3);
        if (cfg_err)   q_err.push_back(rc);
        clk_hist[rc]  <= sccb_clk;
        busy_hist[rc] <= busy;
      end
    end
  end

  bit st_en[MAXC];
  bit st_hold[MAXC];
  bit st_load[MAXC];
  int st_half[MAXC];
  int e_ev[$];
  int e_err[$];
  int p_half[8];
  int p_str[8];
  int cur_half = 50;
  int ld_fix = -1;
  int first_fall, end_cyc, gap_cyc, run_len;

  // Reference model: period p is LOW h+s cycles then HIGH h cycles,
  // mid strobes h/2 into each phase; stimulus is placed on the same timeline.
  task automatic plan(input int n, input int stop_off, input bit reen);
    int f, r, h, s, k, k0, fl, lim;
    for (int i = 0; i < MAXC; i++) begin
      st_en[i] = 0; st_hold[i] = 0; st_load[i] = 0; st_half[i] = 0;
    end
    e_ev.delete();
    e_err.delete();
    st_load[1] = 1; st_half[1] = $urandom_range(0, 1); e_err.push_back(2);
    if (p_half[0] != cur_half) begin st_load[3] = 1; st_half[3] = p_half[0]; end
    f = 5;
    fl = 5;
    first_fall = 5;
    for (int p = 0; p < n; p++) begin
      h = p_half[p];
      s = p_str[p];
      fl = f;
      r = f + h + s;
      e_ev.push_back(f * 4);
      e_ev.push_back((f + h / 2) * 4 + 1);
      e_ev.push_back(r * 4 + 2);
      e_ev.push_back((r + h / 2) * 4 + 3);
      if (s > 0)
        for (int c = f + ((h > 3) ? 3 : h - 1); c <= r - 2; c++) st_hold[c] = 1;
      else if ($urandom_range(0, 1) == 1)
        for (int c = f; c <= f + h - 2; c++) st_hold[c] = 1;
      if ($urandom_range(0, 1) == 1)
        for (int c = r; c < r + h; c++) st_hold[c] = 1;
      if (p + 1 < n && p_half[p + 1] != h) begin
        k = (ld_fix >= 0) ? f + ld_fix : f + $urandom_range(0, r + h - 2 - f);
        if (k > f && $urandom_range(0, 1) == 1) begin
          k0 = $urandom_range(f, k - 1);
          st_load[k0] = 1; st_half[k0] = $urandom_range(2, 60);
        end
        st_load[k] = 1; st_half[k] = p_half[p + 1];
      end
      f = r + h;
    end
    lim = (fl + stop_off < f - 1) ? fl + stop_off : f - 1;
    for (int c = 4; c < lim; c++) st_en[c] = 1;
    cur_half = p_half[n - 1];
    gap_cyc = -1;
    if (reen) begin
      gap_cyc = f;
      st_en[f] = 1;
      h = cur_half;
      e_ev.push_back((f + 1) * 4);
      e_ev.push_back((f + 1 + h / 2) * 4 + 1);
      e_ev.push_back((f + 1 + h) * 4 + 2);
      e_ev.push_back((f + 1 + h + h / 2) * 4 + 3);
      f = f + 1 + 2 * h;
    end
    end_cyc = f;
    run_len = f + 2 * cur_half + 8;
  endtask

  task automatic play();
    logging = 0;
    q_ev.delete();
    q_err.delete();
    @(posedge clk); #1;
    base = cyc;
    logging = 1;
    for (int c = 0; c < run_len; c++) begin
      enable = st_en[c]; hold = st_hold[c]; load = st_load[c];
      half_in = CNT_W'(st_half[c]);
      @(posedge clk); #1;
    end
    logging = 0;
    enable = 0; hold = 0; load = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sccb_clk, busy, tick_fall, mid_low, tick_rise, mid_high, cfg_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 1000000",
               {sccb_clk, busy, tick_fall, mid_low, tick_rise, mid_high, cfg_err});
    end
    resetn = 1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({sccb_clk, busy, tick_fall, mid_low, tick_rise, mid_high, cfg_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL idle_outputs: got %b required 1000000",
               {sccb_clk, busy, tick_fall, mid_low, tick_rise, mid_high, cfg_err});
    end
    cur_half = 50;
  endtask

  task automatic test_async_reset();
    load = 1; half_in = 16'd10;
    @(posedge clk); #1;
    load = 0; enable = 1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin load = 1; half_in = 16'd7; end
      if (i == 2) load = 0;
      if (i == 6) begin
        checks++;
        if (mid_low !== 1'b1 || sccb_clk !== 1'b0) begin
          errors++;
          $display("FAIL async_pre_midlow: got mid_low=%b clk=%b required 1 0", mid_low, sccb_clk);
        end
      end
      if (i == 11) begin
        checks++;
        if (tick_rise !== 1'b1 || sccb_clk !== 1'b1) begin
          errors++;
          $display("FAIL async_pre_rise: got tick_rise=%b clk=%b required 1 1", tick_rise, sccb_clk);
        end
      end
    end
    #2 resetn = 0;
    #1;
    checks++;
    if ({sccb_clk, busy, tick_fall, mid_low, tick_rise, mid_high, cfg_err} !== 7'b1000000) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b required 1000000",
               {sccb_clk, busy, tick_fall, mid_low, tick_rise, mid_high, cfg_err});
    end
    enable = 0;
    @(posedge clk); #1;
    resetn = 1;
    cur_half = 50;
  endtask

  task automatic test_default_rate();
    for (int p = 0; p < 3; p++) begin p_half[p] = 50; p_str[p] = 0; end
    plan(3, $urandom_range(0, 99), 0);
    play();
    checks++;
    if (q_ev.size() != e_ev.size()) begin
      errors++;
      $display("FAIL default_count: got %0d strobes required %0d", q_ev.size(), e_ev.size());
    end
    for (int i = 0; i < e_ev.size() && i < q_ev.size(); i++) begin
      checks++;
      if (q_ev[i] !== e_ev[i]) begin
        errors++;
        $display("FAIL default_ev%0d: got cyc %0d kind %0d required cyc %0d kind %0d",
                 i, q_ev[i] / 4, q_ev[i] % 4, e_ev[i] / 4, e_ev[i] % 4);
      end
    end
    checks++;
    if (q_err.size() != 1 || q_err[0] != e_err[0]) begin
      errors++;
      $display("FAIL default_cfg_err: got %0d pulses required 1 at cyc %0d", q_err.size(), e_err[0]);
    end
    checks++;
    if (busy_hist[first_fall - 1] !== 0 || busy_hist[first_fall] !== 1 ||
        busy_hist[end_cyc - 1] !== 1 || busy_hist[end_cyc] !== 0 || clk_hist[run_len - 1] !== 1) begin
      errors++;
      $display("FAIL default_busy: got %b%b%b%b clk_end=%b required 0110 1", busy_hist[first_fall - 1],
               busy_hist[first_fall], busy_hist[end_cyc - 1], busy_hist[end_cyc], clk_hist[run_len - 1]);
    end
  endtask

  task automatic test_reprogram();
    p_half[0] = 50; p_half[1] = 10; p_half[2] = 10;
    p_str[0] = 0; p_str[1] = 0; p_str[2] = 0;
    ld_fix = 20;
    plan(3, 5, 0);
    ld_fix = -1;
    play();
    checks++;
    if (q_ev.size() != e_ev.size()) begin
      errors++;
      $display("FAIL reprogram_count: got %0d strobes required %0d", q_ev.size(), e_ev.size());
    end
    for (int i = 0; i < e_ev.size() && i < q_ev.size(); i++) begin
      checks++;
      if (q_ev[i] !== e_ev[i]) begin
        errors++;
        $display("FAIL reprogram_ev%0d: got cyc %0d kind %0d required cyc %0d kind %0d",
                 i, q_ev[i] / 4, q_ev[i] % 4, e_ev[i] / 4, e_ev[i] % 4);
      end
    end
    checks++;
    if (busy_hist[end_cyc - 1] !== 1 || busy_hist[end_cyc] !== 0 || clk_hist[run_len - 1] !== 1) begin
      errors++;
      $display("FAIL reprogram_stop: got busy %b%b clk_end=%b required 10 1",
               busy_hist[end_cyc - 1], busy_hist[end_cyc], clk_hist[run_len - 1]);
    end
  endtask

  task automatic test_stretch_stop();
    p_half[0] = 10; p_half[1] = 10; p_str[0] = 20; p_str[1] = 0;
    plan(2, 2, 0);
    play();
    checks++;
    if (q_ev.size() != e_ev.size()) begin
      errors++;
      $display("FAIL stretch_count: got %0d strobes required %0d", q_ev.size(), e_ev.size());
    end
    for (int i = 0; i < e_ev.size() && i < q_ev.size(); i++) begin
      checks++;
      if (q_ev[i] !== e_ev[i]) begin
        errors++;
        $display("FAIL stretch_ev%0d: got cyc %0d kind %0d required cyc %0d kind %0d",
                 i, q_ev[i] / 4, q_ev[i] % 4, e_ev[i] / 4, e_ev[i] % 4);
      end
    end
    checks++;
    if (busy_hist[end_cyc - 1] !== 1 || busy_hist[end_cyc] !== 0 ||
        clk_hist[end_cyc] !== 1 || clk_hist[run_len - 1] !== 1) begin
      errors++;
      $display("FAIL stop_idle: got busy %b%b clk %b%b required 10 11", busy_hist[end_cyc - 1],
               busy_hist[end_cyc], clk_hist[end_cyc], clk_hist[run_len - 1]);
    end
  endtask

  task automatic test_back_to_back();
    p_half[0] = 2; p_str[0] = 3;
    plan(1, 0, 1);
    play();
    checks++;
    if (q_ev.size() != e_ev.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes required %0d", q_ev.size(), e_ev.size());
    end
    for (int i = 0; i < e_ev.size() && i < q_ev.size(); i++) begin
      checks++;
      if (q_ev[i] !== e_ev[i]) begin
        errors++;
        $display("FAIL b2b_ev%0d: got cyc %0d kind %0d required cyc %0d kind %0d",
                 i, q_ev[i] / 4, q_ev[i] % 4, e_ev[i] / 4, e_ev[i] % 4);
      end
    end
    checks++;
    if (busy_hist[gap_cyc] !== 0 || busy_hist[gap_cyc + 1] !== 1 || busy_hist[end_cyc] !== 0) begin
      errors++;
      $display("FAIL b2b_busy: got %b%b%b required 010", busy_hist[gap_cyc],
               busy_hist[gap_cyc + 1], busy_hist[end_cyc]);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int p = 0; p < n; p++) begin
        p_half[p] = $urandom_range(2, 16);
        p_str[p] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      end
      plan(n, $urandom_range(0, 2 * p_half[n - 1] + p_str[n - 1] - 1), 1'($urandom_range(0, 1)));
      play();
      checks++;
      if (q_ev.size() != e_ev.size()) begin
        errors++;
        $display("FAIL random%0d_count: got %0d strobes required %0d", it, q_ev.size(), e_ev.size());
      end
      for (int i = 0; i < e_ev.size() && i < q_ev.size(); i++) begin
        checks++;
        if (q_ev[i] !== e_ev[i]) begin
          errors++;
          $display("FAIL random%0d_ev%0d: got cyc %0d kind %0d required cyc %0d kind %0d",
                   it, i, q_ev[i] / 4, q_ev[i] % 4, e_ev[i] / 4, e_ev[i] % 4);
        end
      end
      checks++;
      if (q_err.size() != 1 || q_err[0] != e_err[0] || busy_hist[end_cyc] !== 0 ||
          busy_hist[end_cyc - 1] !== 1) begin
        errors++;
        $display("FAIL random%0d_err_busy: got %0d err pulses busy %b%b required 1 10", it,
                 q_err.size(), busy_hist[end_cyc - 1], busy_hist[end_cyc]);
      end
    end
  endtask

  task automatic test_no_glitch();
    checks++;
    if (n_glitch != 0) begin
      errors++;
      $display("FAIL clk_glitch: got %0d untimed edges required 0", n_glitch);
    end
    checks++;
    if (n_overlap != 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d overlapping cycles required 0", n_overlap);
    end
  endtask

  initial begin
    enable = 0; load = 0; hold = 0; half_in = '0;
    test_reset();
    test_async_reset();
    test_default_rate();
    test_reprogram();
    test_stretch_stop();
    test_back_to_back();
    test_random();
    test_no_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
